// File: rtl/jstep_seq_pkg.sv
// Shared types and constants for the jstep_seq control sequencer:
// FSM state encoding, phase encoding and the fetch-control decode helper.
package jstep_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_SINGLE = 2'd3
    } state_t;

    localparam logic [1:0] PH_E0  = 2'd0;
    localparam logic [1:0] PH_S   = 2'd1;
    localparam logic [1:0] PH_E1  = 2'd2;
    localparam logic [1:0] PH_GAP = 2'd3;

    typedef struct packed {
        logic bus1;
        logic iar_e;
        logic mar_s;
        logic acc_s;
        logic ram_e;
        logic ir_s;
        logic acc_e;
        logic iar_s;
    } fetch_ctl_t;

    // Fetch steps 1-3 only; enables follow clke, sets follow clks.
    function automatic fetch_ctl_t fetch_decode(input logic [2:0] st,
                                                input logic ce,
                                                input logic cs);
        fetch_ctl_t f;
        f.bus1  = st[0] & ce;
        f.iar_e = st[0] & ce;
        f.mar_s = st[0] & cs;
        f.acc_s = st[0] & cs;
        f.ram_e = st[1] & ce;
        f.ir_s  = st[1] & cs;
        f.acc_e = st[2] & ce;
        f.iar_s = st[2] & cs;
        return f;
    endfunction

endpackage

// File: rtl/jstep_seq_if.sv
// Control/status bundle of the jstep_seq sequencer.
// SINGLE_STEP_EN adds the step_req request line.
interface jstep_seq_if #(parameter int NSTEPS = 6) ();

    logic              run;
    logic              halt;
`ifdef SINGLE_STEP_EN
    logic              step_req;
`endif
    logic [NSTEPS-1:0] step;
    logic              clke;
    logic              clks;
    logic              bus1;
    logic              iar_e;
    logic              mar_s;
    logic              acc_s;
    logic              ram_e;
    logic              ir_s;
    logic              acc_e;
    logic              iar_s;
    logic              busy;
    logic              halted;
    logic              instr_done;

    modport master (
`ifdef SINGLE_STEP_EN
        input  step_req,
`endif
        input  run, halt,
        output step, clke, clks, bus1, iar_e, mar_s, acc_s, ram_e, ir_s,
               acc_e, iar_s, busy, halted, instr_done
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        output step_req,
`endif
        output run, halt,
        input  step, clke, clks, bus1, iar_e, mar_s, acc_s, ram_e, ir_s,
               acc_e, iar_s, busy, halted, instr_done
    );

endinterface

// File: rtl/jstep_ring.sv
// One-hot instruction step ring: resets to step 1 (bit0), rotates left on advance.
module jstep_ring #(
    parameter int NSTEPS = 6
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic              advance,
    output logic [NSTEPS-1:0] step
);

    always_ff @(posedge ref_clk) begin
        if (reset)
            step <= NSTEPS'(1);
        else if (advance)
            step <= {step[NSTEPS-2:0], step[NSTEPS-1]};
    end

endmodule

// File: rtl/jstep_seq.sv
// CPU control sequencer: clke/clks windows, one-hot stepper, fetch controls and
// run/halt sequencing. Define SINGLE_STEP_EN to add the single-step request path.
module jstep_seq
    import jstep_seq_pkg::*;
#(
    parameter int NSTEPS = 6,
    parameter int PHASES = 4
) (
    input  logic       ref_clk,
    input  logic       reset,
    jstep_seq_if.master bus
);

    localparam logic [1:0] PH_END = 2'(PHASES - 1);

    state_t            state, state_nx;
    logic [1:0]        phase, phase_nx;
    logic              advance;
    logic [NSTEPS-1:0] step_q;
    logic              last_step;

    logic              active;
    logic              clke, clks;
    fetch_ctl_t        fetch;

    jstep_ring #(.NSTEPS(NSTEPS)) u_ring (
        .ref_clk (ref_clk),
        .reset   (reset),
        .advance (advance),
        .step    (step_q)
    );

    assign last_step = step_q[NSTEPS-1];

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state <= ST_IDLE;
            phase <= PH_E0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    // The stepper only moves at the end of the gap phase; the last step also
    // decides whether to keep running, pause or halt.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        advance  = 1'b0;
        case (state)
            ST_IDLE: begin
                phase_nx = PH_E0;
                if (bus.run)
                    state_nx = ST_RUN;
`ifdef SINGLE_STEP_EN
                else if (bus.step_req)
                    state_nx = ST_SINGLE;
`endif
            end
            ST_RUN: begin
                phase_nx = phase + 2'd1;
                if (phase == PH_END) begin
                    advance = 1'b1;
                    if (last_step) begin
                        if (bus.halt)
                            state_nx = ST_HALTED;
                        else if (!bus.run)
                            state_nx = ST_IDLE;
                    end
                end
            end
`ifdef SINGLE_STEP_EN
            ST_SINGLE: begin
                phase_nx = phase + 2'd1;
                if (phase == PH_END) begin
                    advance  = 1'b1;
                    state_nx = (last_step && bus.halt) ? ST_HALTED : ST_IDLE;
                end
            end
`endif
            ST_HALTED: phase_nx = PH_E0;
            default: begin
                state_nx = ST_IDLE;
                phase_nx = PH_E0;
            end
        endcase
    end

    // Outputs are masked by reset so no partial window leaks in the reset tick.
    always_comb begin
        active = (state == ST_RUN || state == ST_SINGLE) && !reset;
        clke   = active && (phase == PH_E0 || phase == PH_S || phase == PH_E1);
        clks   = active && (phase == PH_S);
        fetch  = fetch_decode(step_q[2:0], clke, clks);
    end

    assign bus.step       = reset ? NSTEPS'(1) : step_q;
    assign bus.clke       = clke;
    assign bus.clks       = clks;
    assign bus.bus1       = fetch.bus1;
    assign bus.iar_e      = fetch.iar_e;
    assign bus.mar_s      = fetch.mar_s;
    assign bus.acc_s      = fetch.acc_s;
    assign bus.ram_e      = fetch.ram_e;
    assign bus.ir_s       = fetch.ir_s;
    assign bus.acc_e      = fetch.acc_e;
    assign bus.iar_s      = fetch.iar_s;
    assign bus.busy       = (state == ST_RUN) && !reset;
    assign bus.halted     = (state == ST_HALTED) && !reset;
    assign bus.instr_done = active && (phase == PH_GAP) && last_step;

endmodule

// File: tb/tb_jstep_seq.sv
// Self-checking bench for jstep_seq: a position-in-instruction reference model
// plus directed scenario tasks and a randomized run/halt/reset mix.
module tb_jstep_seq;

    localparam int NS  = 6;
    localparam int LEN = 4 * NS;
    localparam int W   = NS + 13;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALT   = 2;
    localparam int M_SINGLE = 3;

    logic ref_clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    int   m_mode = M_IDLE;
    int   m_pos  = 0;

    jstep_seq_if #(.NSTEPS(NS)) bus ();

    jstep_seq #(.NSTEPS(NS), .PHASES(4)) dut (
        .ref_clk (ref_clk),
        .reset   (reset),
        .bus     (bus)
    );

    logic [W-1:0] act;
    assign act = {bus.step, bus.clke, bus.clks, bus.bus1, bus.iar_e, bus.mar_s,
                  bus.acc_s, bus.ram_e, bus.ir_s, bus.acc_e, bus.iar_s,
                  bus.busy, bus.halted, bus.instr_done};

    logic [W-1:0] rst_val;
    assign rst_val = {NS'(1), 13'b0};

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    // Expected outputs from instruction position: step = pos/4, phase = pos%4.
    function automatic logic [W-1:0] exp_out();
        int si, ph;
        logic a, ce, cs;
        logic [NS-1:0] st;
        si = m_pos / 4;
        ph = m_pos % 4;
        a  = (m_mode == M_RUN || m_mode == M_SINGLE) && !reset;
        ce = a && (ph != 3);
        cs = a && (ph == 1);
        st = '0;
        st[reset ? 0 : si] = 1'b1;
        return {st, ce, cs,
                ce && si == 0, ce && si == 0, cs && si == 0, cs && si == 0,
                ce && si == 1, cs && si == 1, ce && si == 2, cs && si == 2,
                (m_mode == M_RUN) && !reset, (m_mode == M_HALT) && !reset,
                a && ph == 3 && si == NS - 1};
    endfunction

    // Advance one ref_clk tick and update the model from the sampled inputs.
    task automatic tick();
        logic r, h, sr, rs, boundary, last;
        r  = bus.run;
        h  = bus.halt;
        rs = reset;
`ifdef SINGLE_STEP_EN
        sr = bus.step_req;
`else
        sr = 1'b0;
`endif
        @(posedge ref_clk);
        if (rs) begin
            m_mode = M_IDLE;
            m_pos  = 0;
        end else if (m_mode == M_IDLE) begin
            if (r)       m_mode = M_RUN;
            else if (sr) m_mode = M_SINGLE;
        end else if (m_mode == M_RUN || m_mode == M_SINGLE) begin
            boundary = (m_pos % 4) == 3;
            last     = (m_pos == LEN - 1);
            m_pos    = (m_pos + 1) % LEN;
            if (boundary) begin
                if (last && h)               m_mode = M_HALT;
                else if (m_mode == M_SINGLE) m_mode = M_IDLE;
                else if (last && !r)         m_mode = M_IDLE;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.run  = 1'b0;
        bus.halt = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.run  = 1'b1;
        bus.halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ref_clk);
            n_cmp++;
            if (act !== rst_val) begin
                n_err++;
                $display("FAIL reset_state i=%0d got=%h want=%h", i, act, rst_val);
            end
            tick();
        end
        bus.run = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_run_free();
        int first_ce, n_done, n_cs;
        int done_t[$];
        do_reset();
        bus.run  = 1'b1;
        first_ce = -1;
        n_done   = 0;
        n_cs     = 0;
        for (int t = 0; t <= 2 * LEN; t++) begin
            @(negedge ref_clk);
            n_cmp++;
            if (act !== exp_out()) begin
                n_err++;
                $display("FAIL run_free t=%0d got=%h want=%h", t, act, exp_out());
            end
            if (bus.clke && first_ce < 0) first_ce = t;
            if (bus.clks) n_cs++;
            if (bus.instr_done) done_t.push_back(t);
            tick();
        end
        n_cmp++;
        if (first_ce !== 1) begin
            n_err++;
            $display("FAIL first_clke got=%0d want=1", first_ce);
        end
        n_cmp++;
        if (n_cs !== 2 * NS) begin
            n_err++;
            $display("FAIL clks_count got=%0d want=%0d", n_cs, 2 * NS);
        end
        n_cmp++;
        if (done_t.size() !== 2 || done_t[0] !== LEN || done_t[1] !== 2 * LEN) begin
            n_err++;
            $display("FAIL instr_done_ticks got=%p want=%0d,%0d", done_t, LEN, 2 * LEN);
        end
    endtask

    task automatic test_run_drop();
        int drop_at, guard;
        do_reset();
        bus.run = 1'b1;
        drop_at = 8 + $urandom_range(3);
        guard   = 0;
        while (!(m_mode == M_RUN && m_pos == drop_at) && guard < 40) begin
            @(negedge ref_clk);
            n_cmp++;
            if (act !== exp_out()) begin
                n_err++;
                $display("FAIL run_drop_pre pos=%0d got=%h want=%h", m_pos, act, exp_out());
            end
            tick();
            guard++;
        end
        bus.run = 1'b0;
        guard   = 0;
        while (m_mode == M_RUN && guard < 40) begin
            @(negedge ref_clk);
            n_cmp++;
            if (act !== exp_out()) begin
                n_err++;
                $display("FAIL run_drop_finish pos=%0d got=%h want=%h", m_pos, act, exp_out());
            end
            tick();
            guard++;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge ref_clk);
            n_cmp++;
            if (act !== rst_val) begin
                n_err++;
                $display("FAIL run_drop_idle i=%0d got=%h want=%h", i, act, rst_val);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        int guard;
        do_reset();
        bus.run = 1'b1;
        guard   = 0;
        while (m_pos != 12 && guard < 40) begin
            @(negedge ref_clk);
            n_cmp++;
            if (act !== exp_out()) begin
                n_err++;
                $display("FAIL halt_pre pos=%0d got=%h want=%h", m_pos, act, exp_out());
            end
            tick();
            guard++;
        end
        bus.halt = 1'b1;
        guard    = 0;
        while (m_mode != M_HALT && guard < 40) begin
            @(negedge ref_clk);
            n_cmp++;
            if (act !== exp_out()) begin
                n_err++;
                $display("FAIL halt_finish pos=%0d got=%h want=%h", m_pos, act, exp_out());
            end
            tick();
            guard++;
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge ref_clk);
            n_cmp++;
            if (act !== {NS'(1), 11'b0, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL halted_hold i=%0d got=%h want=%h", i, act,
                         {NS'(1), 11'b0, 1'b1, 1'b0});
            end
            tick();
        end
        bus.halt = 1'b0;
        bus.run  = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge ref_clk);
        n_cmp++;
        if (act !== rst_val) begin
            n_err++;
            $display("FAIL halt_reset_idle got=%h want=%h", act, rst_val);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        do_reset();
        bus.run = 1'b1;
        guard   = 0;
        while (m_pos != 4 && guard < 20) begin
            @(negedge ref_clk);
            n_cmp++;
            if (act !== exp_out()) begin
                n_err++;
                $display("FAIL reset_mid_pre pos=%0d got=%h want=%h", m_pos, act, exp_out());
            end
            tick();
            guard++;
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge ref_clk);
            n_cmp++;
            if (act !== rst_val) begin
                n_err++;
                $display("FAIL reset_mid i=%0d got=%h want=%h", i, act, rst_val);
            end
            tick();
        end
        bus.run = 1'b0;
        reset   = 1'b0;
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single();
        int n_cs;
        logic [NS-1:0] want_st;
        do_reset();
        bus.step_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.step_req = 1'b1;
            @(negedge ref_clk);
            n_cmp++;
            if (act !== exp_out()) begin
                n_err++;
                $display("FAIL single_req k=%0d got=%h want=%h", k, act, exp_out());
            end
            tick();
            bus.step_req = 1'b0;
            n_cs = 0;
            for (int p = 0; p < 4; p++) begin
                @(negedge ref_clk);
                n_cmp++;
                if (act !== exp_out()) begin
                    n_err++;
                    $display("FAIL single_phase k=%0d p=%0d got=%h want=%h", k, p, act, exp_out());
                end
                if (bus.clks) n_cs++;
                tick();
            end
            want_st = NS'(1) << (k + 1);
            @(negedge ref_clk);
            n_cmp++;
            if (bus.step !== want_st || bus.clke !== 1'b0 || n_cs !== 1) begin
                n_err++;
                $display("FAIL single_done k=%0d step=%b want=%b clke=%b clks_n=%0d",
                         k, bus.step, want_st, bus.clke, n_cs);
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 600; t++) begin
            bus.run  = ($urandom_range(3) != 0);
            bus.halt = ($urandom_range(15) == 0);
            reset    = ($urandom_range(59) == 0);
`ifdef SINGLE_STEP_EN
            bus.step_req = ($urandom_range(3) == 0);
            if ($urandom_range(1) == 0) bus.run = 1'b0;
`endif
            @(negedge ref_clk);
            n_cmp++;
            if (act !== exp_out()) begin
                n_err++;
                $display("FAIL random t=%0d mode=%0d pos=%0d got=%h want=%h",
                         t, m_mode, m_pos, act, exp_out());
            end
            tick();
        end
        reset    = 1'b0;
        bus.run  = 1'b0;
        bus.halt = 1'b0;
`ifdef SINGLE_STEP_EN
        bus.step_req = 1'b0;
`endif
    endtask

    initial begin
        reset    = 1'b1;
        bus.run  = 1'b0;
        bus.halt = 1'b0;
`ifdef SINGLE_STEP_EN
        bus.step_req = 1'b0;
`endif
        test_reset();
        test_run_free();
        test_run_drop();
        test_halt();
        test_reset_mid();
`ifdef SINGLE_STEP_EN
        test_single();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "bench timeout");
    end

endmodule
